// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_REL     = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_BAT_ERR = 8'hFC;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } scan_event_t;

  typedef enum logic [1:0] {StIdle, StExt, StRel, StExtRel} prefix_state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; head reads as zero while empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  scan_event_t push_data_i,
  output logic        full_o,
  output logic        valid_o,
  input  logic        ready_i,
  output scan_event_t head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  scan_event_t     mem_q [DEPTH];
  scan_event_t     mem_d [DEPTH];
  logic            pop, do_push;

  // Pointer, count and storage next-state; a push into a full FIFO is taken only with a pop.
  always_comb begin
    valid_o = (cnt_q != '0);
    full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
    pop     = valid_o && ready_i;
    do_push = push_i && (!full_o || pop);
    head_o  = valid_o ? mem_q[rd_q] : '0;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data_i;
      wr_d        = wr_q + PtrW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PtrW'(1);
    end
    if (do_push && !pop) begin
      cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (!do_push && pop) begin
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: oversampled framing, prefix folding and event buffering.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 250,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  output logic             EV_VALID,
  input  logic             EV_READY,
  output logic [7:0]       EV_CODE,
  output logic             EV_EXT,
  output logic             EV_REL,
  output logic [7:0]       LAST_BYTE,
  output logic             FRAME_ERR,
  output logic             OVERFLOW,
  output logic [ERR_W-1:0] ERR_COUNT
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);

  logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic             prev_clk_q, prev_clk_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [10:0]      shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]   to_q, to_d;
  prefix_state_e    st_q, st_d;
  logic [7:0]       last_byte_q, last_byte_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic        tick, fall, frame_good;
  logic [7:0]  frame_byte;
  logic        emit, fifo_full, fifo_valid;
  scan_event_t ev, head;

  // Frame assembly: tick divider, falling-edge sampling, frame check and timeout.
  always_comb begin
    tick        = (div_q == DivW'(CLK_DIV - 1));
    div_d       = tick ? '0 : div_q + DivW'(1);
    prev_clk_d  = tick ? clk_sync_q : prev_clk_q;
    fall        = tick && prev_clk_q && !clk_sync_q;
    frame_byte  = shift_q[8:1];
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_d        = to_q;
    last_byte_d = last_byte_q;
    frame_good  = 1'b0;
    frame_err_d = 1'b0;
    if (bit_cnt_q == 4'd11) begin
      bit_cnt_d = '0;
      to_d      = '0;
      // Start low, stop high, odd parity over data plus parity bit.
      if (!shift_q[0] && shift_q[10] && (^shift_q[9:1])) begin
        frame_good  = 1'b1;
        last_byte_d = frame_byte;
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (fall) begin
      shift_d   = {dat_sync_q, shift_q[10:1]};
      bit_cnt_d = bit_cnt_q + 4'd1;
      to_d      = '0;
    end else if (tick && (bit_cnt_q != '0)) begin
      if (to_q == ToW'(TIMEOUT_TICKS - 1)) begin
        bit_cnt_d   = '0;
        to_d        = '0;
        frame_err_d = 1'b1;
      end else begin
        to_d = to_q + ToW'(1);
      end
    end
  end

  // Prefix folding: E0/F0 accumulate, any other byte emits an event and returns to idle.
  always_comb begin
    st_d    = st_q;
    emit    = 1'b0;
    ev      = '0;
    ev.code = frame_byte;
    if (frame_err_d) begin
      st_d = StIdle;
    end else if (frame_good) begin
      unique case (st_q)
        StIdle: begin
          if (frame_byte == PS2_EXT)      st_d = StExt;
          else if (frame_byte == PS2_REL) st_d = StRel;
          else                            emit = 1'b1;
        end
        StExt: begin
          if (frame_byte == PS2_REL)      st_d = StExtRel;
          else if (frame_byte != PS2_EXT) begin
            emit   = 1'b1;
            ev.ext = 1'b1;
            st_d   = StIdle;
          end
        end
        StRel: begin
          if (frame_byte == PS2_EXT)      st_d = StExtRel;
          else if (frame_byte != PS2_REL) begin
            emit   = 1'b1;
            ev.rel = 1'b1;
            st_d   = StIdle;
          end
        end
        StExtRel: begin
          if ((frame_byte != PS2_EXT) && (frame_byte != PS2_REL)) begin
            emit   = 1'b1;
            ev.ext = 1'b1;
            ev.rel = 1'b1;
            st_d   = StIdle;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  // Overflow detection and saturating error count.
  always_comb begin
    overflow_d = emit && fifo_full && !(fifo_valid && EV_READY);
    err_cnt_d  = err_cnt_q;
    if ((frame_err_d || overflow_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State registers, including the PS/2 line synchronisers (idle-high reset values).
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      prev_clk_q  <= 1'b1;
      div_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      to_q        <= '0;
      st_q        <= StIdle;
      last_byte_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      clk_meta_q  <= PS2_CLK;
      clk_sync_q  <= clk_meta_q;
      dat_meta_q  <= PS2_DATA;
      dat_sync_q  <= dat_meta_q;
      prev_clk_q  <= prev_clk_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_q        <= to_d;
      st_q        <= st_d;
      last_byte_q <= last_byte_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (emit),
    .push_data_i (ev),
    .full_o      (fifo_full),
    .valid_o     (fifo_valid),
    .ready_i     (EV_READY),
    .head_o      (head)
  );

  assign EV_VALID  = fifo_valid;
  assign EV_CODE   = head.code;
  assign EV_EXT    = head.ext;
  assign EV_REL    = head.rel;
  assign LAST_BYTE = last_byte_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = overflow_q;
  assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver with a byte-level reference model.
module tb_ps2_scan_receiver;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned TIMEOUT_TICKS = 20;
  localparam int unsigned FIFO_DEPTH    = 8;
  localparam int unsigned ERR_W         = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             PS2_CLK = 1'b1;
  logic             PS2_DATA = 1'b1;
  logic             EV_READY;
  logic             EV_VALID, EV_EXT, EV_REL, FRAME_ERR, OVERFLOW;
  logic [7:0]       EV_CODE, LAST_BYTE;
  logic [ERR_W-1:0] ERR_COUNT;

  ps2_scan_receiver #(
    .CLK_DIV       (CLK_DIV),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .ERR_W         (ERR_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .EV_VALID  (EV_VALID),
    .EV_READY  (EV_READY),
    .EV_CODE   (EV_CODE),
    .EV_EXT    (EV_EXT),
    .EV_REL    (EV_REL),
    .LAST_BYTE (LAST_BYTE),
    .FRAME_ERR (FRAME_ERR),
    .OVERFLOW  (OVERFLOW),
    .ERR_COUNT (ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         passes = 0;
  int         pcount = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [9:0] got[$];
  int         rises[$];
  logic [9:0] exp_q[$];
  logic [1:0] ready_mode = 2'd1;
  int         last_fall_p;
  bit         m_ext, m_rel;
  int         exp_fe;

  // Posedges since reset release.
  always @(posedge CLK) begin
    if (RST) pcount <= 0;
    else     pcount <= pcount + 1;
  end

  // Consumer ready: 0 = hold off, 1 = always ready, 2 = random.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      2'd0:    EV_READY = 1'b0;
      2'd1:    EV_READY = 1'b1;
      default: EV_READY = 1'($urandom % 2);
    endcase
  end

  // Monitor: collect popped events, pulses and EV_VALID rise times.
  always @(negedge CLK) begin
    if (!RST) begin
      if (EV_VALID && EV_READY) got.push_back({EV_EXT, EV_REL, EV_CODE});
      if (FRAME_ERR) fe_cnt++;
      if (OVERFLOW) ov_cnt++;
      if (EV_VALID && !valid_prev) rises.push_back(pcount);
    end
    valid_prev = EV_VALID;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Reference model: prefixes set flags, a bad or timed-out frame clears them.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 0;
      m_rel = 0;
      exp_fe++;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      exp_q.push_back({m_ext, m_rel, b});
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    m_ext = 0;
    m_rel = 0;
    exp_fe = 0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      repeat (half) @(posedge CLK);
      #1;
      PS2_CLK = 1'b0;
      last_fall_p = pcount;
      repeat (half) @(posedge CLK);
      #1;
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int half);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    send_bits(bits, 11, half);
  endtask

  task automatic wait_events(input int target);
    int cyc = 0;
    while (got.size() < target && cyc < 3000) begin
      @(posedge CLK);
      cyc++;
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({EV_VALID, EV_CODE, EV_EXT, EV_REL, LAST_BYTE, FRAME_ERR, OVERFLOW, ERR_COUNT} !== '0)
      $display("FAIL reset_outputs: got valid=%b code=%h last=%h err=%h, expected all zero",
               EV_VALID, EV_CODE, LAST_BYTE, ERR_COUNT);
    else passes++;
    do_reset();
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (EV_VALID !== 1'b0 || ERR_COUNT !== '0 || LAST_BYTE !== 8'h00)
      $display("FAIL idle_after_reset: got valid=%b err=%h last=%h, expected 0/0/0",
               EV_VALID, ERR_COUNT, LAST_BYTE);
    else passes++;
  endtask

  task automatic test_single_frame();
    int gb, rb, t;
    do_reset();
    gb = got.size();
    rb = rises.size();
    send_frame(8'h1C, 1'b0, 3 * CLK_DIV);
    model_byte(8'h1C, 1'b1);
    // Stop bit is captured on the first tick at least 3 edges after the drop.
    t = last_fall_p + 3;
    while (t % CLK_DIV != 0) t++;
    wait_events(gb + 1);
    checks++;
    if (rises.size() <= rb || rises[rb] !== t + 1)
      $display("FAIL valid_latency: got rise at edge %0d, expected %0d",
               (rises.size() > rb) ? rises[rb] : -1, t + 1);
    else passes++;
    checks++;
    if (got.size() - gb !== 1 || got[gb] !== exp_q[0])
      $display("FAIL single_event: got %0d events first %h, expected 1 event %h",
               got.size() - gb, (got.size() > gb) ? got[gb] : 10'h3FF, exp_q[0]);
    else passes++;
    checks++;
    if (LAST_BYTE !== 8'h1C) $display("FAIL last_byte: got %h, expected 1c", LAST_BYTE);
    else passes++;
  endtask

  task automatic test_prefixes();
    logic [7:0] seq[5] = '{8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C};
    int gb;
    do_reset();
    gb = got.size();
    foreach (seq[i]) begin
      send_frame(seq[i], 1'b0, 2 * CLK_DIV);
      model_byte(seq[i], 1'b1);
    end
    wait_events(gb + 2);
    checks++;
    if (got.size() - gb !== 2)
      $display("FAIL prefix_count: got %0d events, expected 2", got.size() - gb);
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got.size() <= gb + i || got[gb + i] !== exp_q[i])
        $display("FAIL prefix_event%0d: got %h, expected %h", i,
                 (got.size() > gb + i) ? got[gb + i] : 10'h3FF, exp_q[i]);
      else passes++;
    end
    checks++;
    if (LAST_BYTE !== 8'h1C) $display("FAIL prefix_last_byte: got %h, expected 1c", LAST_BYTE);
    else passes++;
  endtask

  task automatic test_parity_error();
    int gb, fb;
    do_reset();
    gb = got.size();
    fb = fe_cnt;
    send_frame(8'h1C, 1'b1, 3 * CLK_DIV);
    model_byte(8'h1C, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (fe_cnt - fb !== 1 || ERR_COUNT !== 8'd1)
      $display("FAIL parity_err: got pulses=%0d count=%0d, expected 1/1", fe_cnt - fb, ERR_COUNT);
    else passes++;
    checks++;
    if (got.size() !== gb || EV_VALID !== 1'b0)
      $display("FAIL parity_no_event: got %0d events valid=%b, expected 0/0", got.size() - gb,
               EV_VALID);
    else passes++;
    send_frame(8'h16, 1'b0, 3 * CLK_DIV);
    model_byte(8'h16, 1'b1);
    wait_events(gb + 1);
    checks++;
    if (got.size() - gb !== 1 || got[gb] !== exp_q[0] || fe_cnt - fb !== 1)
      $display("FAIL parity_recover: got %0d events first %h errs %0d, expected 1 event %h 1 err",
               got.size() - gb, (got.size() > gb) ? got[gb] : 10'h3FF, fe_cnt - fb, exp_q[0]);
    else passes++;
  endtask

  task automatic test_timeout();
    int gb, fb, k;
    do_reset();
    gb = got.size();
    fb = fe_cnt;
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 3 * CLK_DIV);
    k = last_fall_p;
    while (pcount - k < int'((TIMEOUT_TICKS - 2) * CLK_DIV)) @(posedge CLK);
    #1;
    checks++;
    if (fe_cnt - fb !== 0) $display("FAIL timeout_early: got %0d errors, expected 0", fe_cnt - fb);
    else passes++;
    while (pcount - k < int'((TIMEOUT_TICKS + 3) * CLK_DIV)) @(posedge CLK);
    #1;
    checks++;
    if (fe_cnt - fb !== 1 || ERR_COUNT !== 8'd1)
      $display("FAIL timeout_err: got pulses=%0d count=%0d, expected 1/1", fe_cnt - fb, ERR_COUNT);
    else passes++;
    send_frame(8'h29, 1'b0, 3 * CLK_DIV);
    model_byte(8'h29, 1'b1);
    wait_events(gb + 1);
    checks++;
    if (got.size() - gb !== 1 || got[gb] !== exp_q[0])
      $display("FAIL timeout_recover: got %0d events first %h, expected 1 event %h",
               got.size() - gb, (got.size() > gb) ? got[gb] : 10'h3FF, exp_q[0]);
    else passes++;
  endtask

  task automatic test_overflow();
    int gb, ob;
    do_reset();
    ready_mode = 2'd0;
    @(posedge CLK);
    #1;
    gb = got.size();
    ob = ov_cnt;
    for (int i = 0; i <= int'(FIFO_DEPTH); i++) begin
      send_frame(8'(8'h15 + i), 1'b0, 2 * CLK_DIV);
      if (i < int'(FIFO_DEPTH)) model_byte(8'(8'h15 + i), 1'b1);
      if (i == 2 || i == 5) begin
        checks++;
        if (EV_VALID !== 1'b1 || EV_CODE !== 8'h15)
          $display("FAIL head_stable%0d: got valid=%b code=%h, expected 1/15", i, EV_VALID,
                   EV_CODE);
        else passes++;
      end
    end
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (ov_cnt - ob !== 1 || ERR_COUNT !== 8'd1)
      $display("FAIL overflow: got pulses=%0d count=%0d, expected 1/1", ov_cnt - ob, ERR_COUNT);
    else passes++;
    ready_mode = 2'd1;
    wait_events(gb + int'(FIFO_DEPTH));
    checks++;
    if (got.size() - gb !== int'(FIFO_DEPTH))
      $display("FAIL drain_count: got %0d, expected %0d", got.size() - gb, FIFO_DEPTH);
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got.size() <= gb + i || got[gb + i] !== exp_q[i])
        $display("FAIL drain%0d: got %h, expected %h", i,
                 (got.size() > gb + i) ? got[gb + i] : 10'h3FF, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int gb, fb;
    do_reset();
    send_frame(8'hE0, 1'b0, 2 * CLK_DIV);
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 4, 2 * CLK_DIV);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({EV_VALID, EV_CODE, EV_EXT, EV_REL, LAST_BYTE, FRAME_ERR, OVERFLOW, ERR_COUNT} !== '0)
        $display("FAIL mid_reset_outputs%0d: got last=%h err=%h, expected all zero", i,
                 LAST_BYTE, ERR_COUNT);
      else passes++;
    end
    do_reset();
    gb = got.size();
    fb = fe_cnt;
    send_frame(8'h74, 1'b0, 2 * CLK_DIV);
    model_byte(8'h74, 1'b1);
    wait_events(gb + 1);
    checks++;
    if (got.size() - gb !== 1 || got[gb] !== exp_q[0] || fe_cnt - fb !== 0)
      $display("FAIL mid_reset_event: got %0d events first %h errs %0d, expected 1 event %h 0 errs",
               got.size() - gb, (got.size() > gb) ? got[gb] : 10'h3FF, fe_cnt - fb, exp_q[0]);
    else passes++;
  endtask

  task automatic test_random();
    int gb, fb;
    logic [7:0] b, last_good;
    do_reset();
    ready_mode = 2'd2;
    gb = got.size();
    fb = fe_cnt;
    last_good = 8'h00;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] seq[$];
      bit         bad[$];
      if ($urandom % 2) begin seq.push_back(8'hE0); bad.push_back(0); end
      if ($urandom % 2) begin seq.push_back(8'hF0); bad.push_back(0); end
      if ($urandom % 3 == 0) begin seq.push_back(8'hE0); bad.push_back(0); end
      if ($urandom % 6 == 0) begin seq.push_back(8'($urandom)); bad.push_back(1); end
      do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
      seq.push_back(b);
      bad.push_back(0);
      foreach (seq[i]) begin
        send_frame(seq[i], bad[i], int'($urandom_range(2, 4)) * CLK_DIV);
        model_byte(seq[i], !bad[i]);
        if (!bad[i]) last_good = seq[i];
      end
    end
    ready_mode = 2'd1;
    wait_events(gb + exp_q.size());
    checks++;
    if (got.size() - gb !== exp_q.size())
      $display("FAIL rand_count: got %0d, expected %0d", got.size() - gb, exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got.size() <= gb + i || got[gb + i] !== exp_q[i])
        $display("FAIL rand_event%0d: got %h, expected %h", i,
                 (got.size() > gb + i) ? got[gb + i] : 10'h3FF, exp_q[i]);
      else passes++;
    end
    checks++;
    if (fe_cnt - fb !== exp_fe || ERR_COUNT !== ERR_W'(exp_fe))
      $display("FAIL rand_errors: got pulses=%0d count=%0d, expected %0d", fe_cnt - fb,
               ERR_COUNT, exp_fe);
    else passes++;
    checks++;
    if (LAST_BYTE !== last_good)
      $display("FAIL rand_last_byte: got %h, expected %h", LAST_BYTE, last_good);
    else passes++;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_single_frame();
    test_prefixes();
    test_parity_error();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
